// File: rtl/reg_arb4_pkg.sv
// reg_arb4_pkg
// Shared constants for the four-requester register arbiter: command
// encodings, FSM state encodings, reset pointer value and the
// round-robin winner search used by the arbiter.
package reg_arb4_pkg;

  localparam int NREQ = 4;

  // Requester 0 gets first priority after reset.
  localparam logic [1:0] LAST_RESET = 2'd3;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_SET   = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_HOLD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ACK   = 2'b10
  } state_e;

  // Scan last+1, last+2, last+3, last (mod 4); the first requesting
  // index wins. The 2-bit sum wraps naturally. If no request is set
  // the result is 'last', which callers ignore.
  function automatic logic [1:0] rr_winner(input logic [3:0] req,
                                           input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/reg_arb4_reg_rs.sv
// reg_arb4_reg_rs
// WIDTH-bit storage register with asynchronous active-low reset and
// synchronous clear / set / load, all qualified by en. With en high and
// no operation strobe, the value is held.
// Ports:
//   clk, reset_n : clock, async active-low reset (clears q)
//   en           : enables the synchronous operations
//   clr, set     : force all zeros / all ones (clear wins over set)
//   load, d      : load d
//   q            : stored value
module reg_arb4_reg_rs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with async reset and prioritised synchronous operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      if (clr) begin
        q <= {WIDTH{1'b0}};
      end else if (set) begin
        q <= {WIDTH{1'b1}};
      end else if (load) begin
        q <= d;
      end else begin
        q <= q;
      end
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/reg_arb4.sv
// reg_arb4
// Four-requester round-robin arbiter in front of one shared WIDTH-bit
// register. Each access takes IDLE -> GRANT -> ACK -> IDLE: the winner's
// command and data are latched on the IDLE edge, the register is written
// on the GRANT edge, and ack pulses for one cycle in ACK.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   req[3:0]     : request per requester
//   cmd[7:0]     : 2-bit command per requester, [2i+1:2i]
//   wdata        : WIDTH-bit write data per requester, slice i
//   gnt[3:0]     : registered one-hot grant (high during GRANT)
//   ack[3:0]     : registered one-hot completion pulse (high during ACK)
//   q            : shared register value
//   busy         : state is not IDLE
module reg_arb4
  import reg_arb4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [7:0]         cmd,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  state_e           state;
  state_e           state_nx;
  logic [1:0]       last;
  logic [1:0]       last_nx;
  cmd_e             cmd_lat;
  cmd_e             cmd_lat_nx;
  logic [WIDTH-1:0] data_lat;
  logic [WIDTH-1:0] data_lat_nx;
  logic [3:0]       gnt_nx;
  logic [3:0]       ack_nx;
  logic [1:0]       win;
  logic             reg_en;
  logic             reg_clr;
  logic             reg_set;
  logic             reg_load;

  logic [1:0]       cmd_vec   [NREQ];
  logic [WIDTH-1:0] wdata_vec [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_vec[i]   = cmd[2*i +: 2];
    assign wdata_vec[i] = wdata[WIDTH*i +: WIDTH];
  end

  assign win  = rr_winner(req, last);
  assign busy = (state != ST_IDLE);

  // Next-state, grant/ack and latch logic.
  always_comb begin
    state_nx    = state;
    last_nx     = last;
    cmd_lat_nx  = cmd_lat;
    data_lat_nx = data_lat;
    gnt_nx      = gnt;
    ack_nx      = ack;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nx    = ST_GRANT;
          last_nx     = win;
          cmd_lat_nx  = cmd_e'(cmd_vec[win]);
          data_lat_nx = wdata_vec[win];
          gnt_nx      = 4'b0001 << win;
          ack_nx      = 4'b0000;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Grant hands over to ack for the same requester; inputs ignored.
        state_nx = ST_ACK;
        gnt_nx   = 4'b0000;
        ack_nx   = gnt;
      end
      ST_ACK: begin
        state_nx = ST_IDLE;
        gnt_nx   = 4'b0000;
        ack_nx   = 4'b0000;
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = 4'b0000;
        ack_nx   = 4'b0000;
      end
    endcase
  end

  // Register-write strobes: the write happens on the GRANT -> ACK edge.
  always_comb begin
    reg_en   = (state == ST_GRANT);
    reg_clr  = 1'b0;
    reg_set  = 1'b0;
    reg_load = 1'b0;
    case (cmd_lat)
      CMD_LOAD:  reg_load = 1'b1;
      CMD_SET:   reg_set  = 1'b1;
      CMD_CLEAR: reg_clr  = 1'b1;
      CMD_HOLD:  reg_load = 1'b0;
      default:   reg_load = 1'b0;
    endcase
  end

  // FSM state, round-robin pointer, latched command and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      last     <= LAST_RESET;
      cmd_lat  <= CMD_LOAD;
      data_lat <= {WIDTH{1'b0}};
      gnt      <= 4'b0000;
      ack      <= 4'b0000;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      cmd_lat  <= cmd_lat_nx;
      data_lat <= data_lat_nx;
      gnt      <= gnt_nx;
      ack      <= ack_nx;
    end
  end

  reg_arb4_reg_rs #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (reg_en),
    .clr     (reg_clr),
    .set     (reg_set),
    .load    (reg_load),
    .d       (data_lat),
    .q       (q)
  );

endmodule

// File: tb/tb_reg_arb4.sv
// tb_reg_arb4
// Directed and randomized checks of reg_arb4 against a small behavioural
// model (current register value plus last-granted index).
module tb_reg_arb4;
  import reg_arb4_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [3:0]     req;
  logic [7:0]     cmd;
  logic [4*W-1:0] wdata;
  logic [3:0]     gnt;
  logic [3:0]     ack;
  logic [W-1:0]   q;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_q;
  int           m_last;

  always #5 clk = ~clk;

  reg_arb4 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .cmd     (cmd),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester in order last+1 .. last+4 (mod 4).
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_next(input logic [1:0] c, input logic [W-1:0] d,
                                              input logic [W-1:0] cur);
    case (cmd_e'(c))
      CMD_LOAD:  return d;
      CMD_SET:   return {W{1'b1}};
      CMD_CLEAR: return {W{1'b0}};
      default:   return cur;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic access(input logic [3:0] r, input logic [7:0] c, input logic [4*W-1:0] d,
                        input bit drop, input string tag);
    int w;
    logic [W-1:0] exp_q;
    req = r; cmd = c; wdata = d;
    w = model_pick(r);
    @(posedge clk); #1;
    if (w < 0) begin
      check({tag, "/idle_gnt"}, gnt, 0);
      check({tag, "/idle_ack"}, ack, 0);
      check({tag, "/idle_busy"}, busy, 0);
      check({tag, "/idle_q"}, q, m_q);
      @(negedge clk);
    end else begin
      exp_q  = model_next(c[2*w +: 2], d[W*w +: W], m_q);
      m_last = w;
      check({tag, "/gnt"}, gnt, 32'(1) << w);
      check({tag, "/gnt_ack"}, ack, 0);
      check({tag, "/gnt_busy"}, busy, 1);
      check({tag, "/gnt_q"}, q, m_q);
      @(negedge clk);
      if (drop) begin
        req   = req & ~(4'b0001 << w);
        cmd   = 8'($urandom);
        wdata = 32'($urandom);
      end
      @(posedge clk); #1;
      m_q = exp_q;
      check({tag, "/ack"}, ack, 32'(1) << w);
      check({tag, "/ack_gnt"}, gnt, 0);
      check({tag, "/ack_q"}, q, m_q);
      check({tag, "/ack_busy"}, busy, 1);
      @(posedge clk); #1;
      check({tag, "/end_ack"}, ack, 0);
      check({tag, "/end_gnt"}, gnt, 0);
      check({tag, "/end_q"}, q, m_q);
      check({tag, "/end_busy"}, busy, 0);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    req = 4'b0000; cmd = 8'h00; wdata = '0;
    reset_n = 1'b0;
    #1;
    m_q = '0; m_last = 3;
    check({tag, "/rst_gnt"}, gnt, 0);
    check({tag, "/rst_ack"}, ack, 0);
    check({tag, "/rst_q"}, q, 0);
    check({tag, "/rst_busy"}, busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rr;
    reset_n = 1'b1; req = 4'b0000; cmd = 8'h00; wdata = '0;
    m_q = '0; m_last = 3;
    @(negedge clk);
    do_reset("init");

    // No request: nothing changes.
    access(4'b0000, 8'h00, 32'h0, 1'b0, "noreq");

    // Single access, requester 0 loads 0xA5.
    access(4'b0001, 8'h00, 32'h000000A5, 1'b0, "single");

    // Full contention from reset: grants 0,1,2,3,0.
    do_reset("pre_cont");
    for (int i = 0; i < 5; i++) access(4'b1111, 8'h00, 32'h44332211, 1'b0, "contend");

    // Commands.
    access(4'b0100, 8'h10, 32'h0, 1'b0, "set2");
    access(4'b0010, 8'h08, 32'h0, 1'b0, "clear1");
    access(4'b0001, 8'h00, 32'h0000005A, 1'b0, "load0");
    access(4'b1000, 8'hC0, 32'hFF000000, 1'b0, "hold3");

    // Pointer: after grant to 1, req=1010 grants 3 then 1.
    access(4'b0010, 8'h00, 32'h00007700, 1'b0, "ptr1");
    access(4'b1010, 8'h00, 32'h66005500, 1'b0, "ptr3");
    access(4'b1010, 8'h00, 32'h66005500, 1'b0, "ptr1b");

    // Requester 2 drops req during GRANT; LOAD 0x3C still completes.
    access(4'b0100, 8'h00, 32'h003C0000, 1'b1, "drop2");

    // Reset during GRANT aborts the access.
    req = 4'b0100; cmd = 8'h10; wdata = '0;
    @(posedge clk); #1;
    check("midrst/gnt", gnt, 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    m_q = '0; m_last = 3;
    check("midrst/q", q, 0);
    check("midrst/gnt0", gnt, 0);
    check("midrst/ack0", ack, 0);
    check("midrst/busy0", busy, 0);
    @(negedge clk);
    reset_n = 1'b1; req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("midrst/noack", ack, 0);
      check("midrst/q_hold", q, 0);
    end
    @(negedge clk);
    access(4'b1010, 8'h00, 32'h00009900, 1'b0, "midrst_next");

    // Randomized accesses with random input scrambling during GRANT.
    for (int i = 0; i < 40; i++) begin
      rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      access(rr, 8'($urandom), 32'($urandom), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
